// File: rtl/dqm_pkg.sv
// Shared types and constants for the serial DQM frame deframer.
package dqm_pkg;

  localparam int DQM_SYNC_WIDTH  = 16;
  localparam int DQM_HEADER_SIZE = 48;

  typedef logic [DQM_SYNC_WIDTH-1:0] hdr_word_t;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } dqm_state_t;

endpackage

// File: rtl/dqm_sync_detect.sv
// Sync window: 16-bit serial shift register plus a comparator that includes the bit being accepted.
// Comparator is combinational; the register advances only on bit_en, so a stalled stream holds its window.
module dqm_sync_detect
  import dqm_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_in,
  input  logic                      bit_en,
  input  logic [DQM_SYNC_WIDTH-1:0] sync_word,
  output logic [DQM_SYNC_WIDTH-1:0] shift_q,
  output logic                      match
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
    end else if (bit_en) begin
      shift_q <= {shift_q[DQM_SYNC_WIDTH-2:0], bit_in};
    end
  end

  assign match = ({shift_q[DQM_SYNC_WIDTH-2:0], bit_in} == sync_word);

endmodule

// File: rtl/dqm_deframer.sv
// DQM deframer: sync search/check, header capture, payload strobes; miss tolerance via DQM_DEFRAMER_FLYWHEEL_EN.
// All outputs appear one cycle after the accepted bit; no backpressure, bit_en=0 stalls the whole frame walk.
module dqm_deframer
  import dqm_pkg::*;
#(
  parameter int HEADER_SIZE = DQM_HEADER_SIZE,
  parameter int MISS_LIMIT  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_in,
  input  logic                      bit_en,
  input  logic [DQM_SYNC_WIDTH-1:0] sync_word,
  input  logic [15:0]               block_size,
  output logic [DQM_SYNC_WIDTH-1:0] frame_word_1,
  output logic [DQM_SYNC_WIDTH-1:0] frame_word_2,
  output logic                      header_valid,
  output logic                      payload_bit,
  output logic                      payload_valid,
  output logic                      locked,
  output logic                      interrupt
);

  localparam int                HDR_BITS = HEADER_SIZE - DQM_SYNC_WIDTH;
  localparam int                MISS_W   = $clog2(MISS_LIMIT + 1);
  localparam logic [15:0]       HDR_LAST = 16'(HDR_BITS - 1);
  localparam logic [15:0]       W1_DONE  = 16'(DQM_SYNC_WIDTH);
  localparam logic [15:0]       W2_LAST  = 16'(2 * DQM_SYNC_WIDTH - 1);
  localparam logic [15:0]       CHK_LAST = 16'(DQM_SYNC_WIDTH - 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  dqm_state_t        state_q, state_d;
  logic [15:0]       cnt_q;
  logic [15:0]       blk_q;
  logic [MISS_W-1:0] miss_q, miss_inc;
  hdr_word_t         sr_q, window, w1_sh, w2_sh;
  logic              sync_match, lose_lock;
  logic              hdr_last, pay_last, chk_last;

  dqm_sync_detect u_sync (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_en    (bit_en),
    .sync_word (sync_word),
    .shift_q   (sr_q),
    .match     (sync_match)
  );

  assign window   = {sr_q[DQM_SYNC_WIDTH-2:0], bit_in};
  assign hdr_last = (cnt_q == HDR_LAST);
  assign pay_last = (cnt_q == blk_q - 16'd1);
  assign chk_last = (cnt_q == CHK_LAST);
  assign miss_inc = (miss_q == MISS_MAX) ? miss_q : miss_q + MISS_ONE;

`ifdef DQM_DEFRAMER_FLYWHEEL_EN
  assign lose_lock = (miss_inc == MISS_MAX);
`else
  assign lose_lock = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      case (state_q)
        ST_SEARCH:  if (sync_match) state_d = ST_HEADER;
        ST_HEADER:  if (hdr_last) state_d = (block_size != 16'd0) ? ST_PAYLOAD : ST_CHECK;
        ST_PAYLOAD: if (pay_last) state_d = ST_CHECK;
        ST_CHECK:   if (chk_last) state_d = (sync_match || !lose_lock) ? ST_HEADER : ST_SEARCH;
        default:    state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      blk_q         <= '0;
      miss_q        <= '0;
      w1_sh         <= '0;
      w2_sh         <= '0;
      frame_word_1  <= '0;
      frame_word_2  <= '0;
      header_valid  <= 1'b0;
      payload_bit   <= 1'b0;
      payload_valid <= 1'b0;
      locked        <= 1'b0;
    end else begin
      header_valid  <= 1'b0;
      payload_valid <= 1'b0;
      if (bit_en) begin
        // Every state change restarts the bit count for the new field.
        cnt_q <= (state_d != state_q || state_q == ST_SEARCH) ? 16'd0 : cnt_q + 16'd1;
        case (state_q)
          ST_HEADER: begin
            // The shift register holds the whole first word once the 17th header bit arrives.
            if (cnt_q == W1_DONE) w1_sh <= sr_q;
            if (cnt_q == W2_LAST) w2_sh <= window;
            if (hdr_last) begin
              frame_word_1 <= w1_sh;
              frame_word_2 <= (HDR_BITS == 2 * DQM_SYNC_WIDTH) ? window : w2_sh;
              header_valid <= 1'b1;
              blk_q        <= block_size;
            end
          end
          ST_PAYLOAD: begin
            payload_bit   <= bit_in;
            payload_valid <= 1'b1;
          end
          ST_CHECK: begin
            if (chk_last) begin
              if (sync_match) begin
                miss_q <= '0;
                locked <= 1'b1;
              end else begin
                miss_q <= miss_inc;
                if (lose_lock) locked <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign interrupt = header_valid & locked;

endmodule

// File: tb/tb_dqm_deframer.sv
// Randomised and directed bench for dqm_deframer against a frame-level reference parser.
module tb_dqm_deframer;

  localparam int MAXN = 4096;
  localparam int ML   = 3;
  localparam int F    = 56;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_en = 1'b0;
  logic [15:0] sync_word = 16'hFAF3;
  logic [15:0] block_size = 16'd8;
  logic [15:0] frame_word_1, frame_word_2;
  logic        header_valid, payload_bit, payload_valid, locked, interrupt;

  dqm_deframer #(.HEADER_SIZE(48), .MISS_LIMIT(ML)) dut (
    .clk           (clk),
    .rst           (rst),
    .bit_in        (bit_in),
    .bit_en        (bit_en),
    .sync_word     (sync_word),
    .block_size    (block_size),
    .frame_word_1  (frame_word_1),
    .frame_word_2  (frame_word_2),
    .header_valid  (header_valid),
    .payload_bit   (payload_bit),
    .payload_valid (payload_valid),
    .locked        (locked),
    .interrupt     (interrupt)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          abit   [MAXN];
  int          nb;
  bit          exp_hv [MAXN];
  bit          exp_pv [MAXN];
  bit          exp_pb [MAXN];
  bit          exp_lk [MAXN];
  logic [15:0] exp_w1 [MAXN];
  logic [15:0] exp_w2 [MAXN];
  bit [1:0]    mdl_chg[MAXN];

  bit          mon_on = 1'b0;
  bit          chk_spacing = 1'b0;
  int          kidx, obs_hv, obs_pv, last_hv_k, mon_kk;
  bit          mon_en, mon_eh, mon_ep, mon_eb, cur_lk;
  logic [15:0] cur_w1, cur_w2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // 16-bit window ending at accepted bit k; history before reset reads as zero.
  function automatic logic [15:0] win(input int k);
    logic [15:0] w;
    int idx;
    w = '0;
    for (int j = 0; j < 16; j++) begin
      idx = k - 15 + j;
      w = {w[14:0], (idx >= 0) ? abit[idx] : 1'b0};
    end
    return w;
  endfunction

  // Frame-level parse of the accepted bit stream: find sync, walk header/payload, check next sync.
  task automatic mdl_build(input int n, input logic [15:0] sync, input int blk);
    int p, k, c, miss;
    bit srch, lose, lk;
    logic [15:0] cw1, cw2;
    for (int i = 0; i < n; i++) begin
      exp_hv[i] = 0; exp_pv[i] = 0; exp_pb[i] = 0; mdl_chg[i] = 0;
      exp_w1[i] = '0; exp_w2[i] = '0;
    end
    p = 0; srch = 1; miss = 0;
    while (p < n) begin
      if (srch) begin
        k = p;
        while (k < n && win(k) != sync) k++;
        if (k >= n) break;
        p = k + 1;
        srch = 0;
      end
      if (p + 31 >= n) break;
      exp_hv[p+31] = 1;
      exp_w1[p+31] = win(p + 15);
      exp_w2[p+31] = win(p + 31);
      for (int j = 0; j < blk; j++)
        if (p + 32 + j < n) begin
          exp_pv[p+32+j] = 1;
          exp_pb[p+32+j] = abit[p+32+j];
        end
      c = p + 32 + blk + 15;
      if (c >= n) break;
      if (win(c) == sync) begin
        miss = 0;
        mdl_chg[c] = 1;
      end else begin
        miss = (miss < ML) ? miss + 1 : ML;
`ifdef DQM_DEFRAMER_FLYWHEEL_EN
        lose = (miss == ML);
`else
        lose = 1;
`endif
        if (lose) begin
          mdl_chg[c] = 2;
          srch = 1;
        end
      end
      p = c + 1;
    end
    lk = 0; cw1 = '0; cw2 = '0;
    for (int i = 0; i < n; i++) begin
      if (mdl_chg[i] == 1) lk = 1;
      else if (mdl_chg[i] == 2) lk = 0;
      exp_lk[i] = lk;
      if (exp_hv[i]) begin cw1 = exp_w1[i]; cw2 = exp_w2[i]; end
      exp_w1[i] = cw1;
      exp_w2[i] = cw2;
    end
  endtask

  task automatic push(input logic [63:0] v, input int w);
    for (int j = w - 1; j >= 0; j--) begin
      abit[nb] = v[j];
      nb++;
    end
  endtask

  task automatic push_frame(input logic [15:0] s, input logic [15:0] h1, input logic [15:0] h2,
                            input int blk, input logic [63:0] pay);
    push({48'd0, s}, 16);
    push({48'd0, h1}, 16);
    push({48'd0, h2}, 16);
    if (blk > 0) push(pay, blk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_w1"}, frame_word_1, 0);
    chk({tag, "_w2"}, frame_word_2, 0);
    chk({tag, "_hv"}, header_valid, 0);
    chk({tag, "_pv"}, payload_valid, 0);
    chk({tag, "_pb"}, payload_bit, 0);
    chk({tag, "_lock"}, locked, 0);
    chk({tag, "_irq"}, interrupt, 0);
  endtask

  task automatic do_reset();
    mon_on = 0; bit_en = 0; bit_in = 0; rst = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    kidx = 0; cur_lk = 0; cur_w1 = '0; cur_w2 = '0;
    obs_hv = 0; obs_pv = 0; last_hv_k = -1;
    rst = 1;
  endtask

  // mode 0: continuous, 1: bit_en pattern 1,0,0,1, 2: random bit_en.
  task automatic drive(input int mode, input int limit);
    int idx, cyc;
    bit en;
    idx = 0; cyc = 0;
    mon_on = 1;
    while (idx < limit) begin
      @(negedge clk);
      case (mode)
        0:       en = 1;
        1:       en = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: en = ($urandom_range(9) < 7);
      endcase
      cyc++;
      bit_en = en;
      if (en) begin
        bit_in = abit[idx];
        idx++;
      end else begin
        bit_in = 1'($urandom_range(1));
      end
    end
    @(negedge clk);
    bit_en = 0; bit_in = 0;
    repeat (3) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    mon_en = bit_en;
    #2;
    if (mon_on && rst) begin
      mon_eh = 0; mon_ep = 0; mon_eb = 0;
      if (mon_en) begin
        mon_kk = kidx;
        kidx++;
        if (mon_kk < MAXN) begin
          mon_eh = exp_hv[mon_kk]; mon_ep = exp_pv[mon_kk]; mon_eb = exp_pb[mon_kk];
          cur_lk = exp_lk[mon_kk]; cur_w1 = exp_w1[mon_kk]; cur_w2 = exp_w2[mon_kk];
        end
      end
      chk("header_valid", header_valid, mon_eh);
      chk("payload_valid", payload_valid, mon_ep);
      chk("locked", locked, cur_lk);
      chk("interrupt", interrupt, mon_eh & cur_lk);
      chk("frame_word_1", frame_word_1, cur_w1);
      chk("frame_word_2", frame_word_2, cur_w2);
      if (mon_ep) chk("payload_bit", payload_bit, mon_eb);
      if (header_valid) begin
        obs_hv++;
        if (chk_spacing && last_hv_k >= 0) chk("hv_spacing", kidx - 1 - last_hv_k, 48);
        last_hv_k = kidx - 1;
      end
      if (payload_valid) obs_pv++;
    end
  end

  initial begin
    int fh, cnt, blk, pre, tot_hv, tot_pv;
    logic [7:0]  pbyte;
    logic [15:0] s;

    // Nominal frames FAF3/1234/5678/A5, continuous bit_en.
    do_reset();
    sync_word = 16'hFAF3; block_size = 16'd8; nb = 0;
    repeat (4) push_frame(16'hFAF3, 16'h1234, 16'h5678, 8, 64'hA5);
    mdl_build(nb, sync_word, 8);
    fh = -1;
    for (int i = 0; i < nb; i++) if (exp_hv[i] && fh < 0) fh = i;
    chk("pin_first_hv_idx", fh, 47);
    chk("pin_first_w1", exp_w1[47], 16'h1234);
    chk("pin_first_w2", exp_w2[47], 16'h5678);
    pbyte = '0; cnt = 0;
    for (int i = 48; i < 56; i++) begin
      pbyte = {pbyte[6:0], exp_pb[i]};
      cnt += int'(exp_pv[i]);
    end
    chk("pin_payload_byte", pbyte, 8'hA5);
    chk("pin_payload_cnt", cnt, 8);
    fh = -1;
    for (int i = 0; i < nb; i++) if (exp_lk[i] && fh < 0) fh = i;
    chk("pin_lock_idx", fh, 71);
    drive(0, nb);
    mon_on = 0;
    chk("nom_hv_count", obs_hv, 4);
    chk("nom_pv_count", obs_pv, 32);
    chk("nom_w1_final", frame_word_1, 16'h1234);
    chk("nom_w2_final", frame_word_2, 16'h5678);

    // Same frames with bit_en toggling 1,0,0,1.
    do_reset();
    drive(1, nb);
    mon_on = 0;
    chk("gap_hv_count", obs_hv, 4);
    chk("gap_pv_count", obs_pv, 32);
    chk("gap_w1_final", frame_word_1, 16'h1234);

    // Zero-length payload: back-to-back 48-bit frames.
    do_reset();
    block_size = 16'd0; nb = 0;
    repeat (6) push_frame(16'hFAF3, 16'($urandom), 16'($urandom), 0, 64'd0);
    mdl_build(nb, sync_word, 0);
    cnt = 0;
    for (int i = 0; i < nb; i++) cnt += int'(exp_hv[i]);
    chk("pin_b0_hv_total", cnt, 6);
    chk_spacing = 1;
    drive(0, nb);
    mon_on = 0; chk_spacing = 0;
    chk("b0_hv_count", obs_hv, 6);
    chk("b0_no_payload", obs_pv, 0);

    // Corrupted syncs at frames 2, 5, 6, 7.
    do_reset();
    block_size = 16'd8; nb = 0;
    for (int f = 0; f < 11; f++) begin
      s = (f == 2 || f == 5 || f == 6 || f == 7) ? 16'h0000 : 16'hFAF3;
      push_frame(s, 16'h1234, 16'h5678, 8, 64'hA5);
    end
    mdl_build(nb, sync_word, 8);
`ifdef DQM_DEFRAMER_FLYWHEEL_EN
    chk("pin_lock_after_1bad", exp_lk[2*F+15], 1);
    chk("pin_hv_after_1bad", exp_hv[2*F+47], 1);
    chk("pin_lock_next_good", exp_lk[3*F+15], 1);
    chk("pin_lock_2_of_3_bad", exp_lk[6*F+15], 1);
`else
    chk("pin_lock_after_1bad", exp_lk[2*F+15], 0);
    chk("pin_hv_after_1bad", exp_hv[2*F+47], 0);
    chk("pin_lock_first_resync", exp_lk[3*F+15], 0);
    chk("pin_lock_second_sync", exp_lk[4*F+15], 1);
`endif
    chk("pin_lock_3bad", exp_lk[7*F+15], 0);
    chk("pin_relock", exp_lk[9*F+15], 1);
    drive(0, nb);
    mon_on = 0;

    // Reset in the middle of frame 2's payload.
    do_reset();
    nb = 0;
    repeat (4) push_frame(16'hFAF3, 16'h1234, 16'h5678, 8, 64'hA5);
    mdl_build(nb, sync_word, 8);
    drive(0, 2*F + 51);
    mon_on = 0;
    chk("pre_rst_locked", locked, 1);
    @(negedge clk);
    #1 rst = 0;
    #1 chk_zero("async_rst");
    do_reset();
    nb = 0;
    push(64'd0, 40);
    repeat (3) push_frame(16'hFAF3, 16'hBEEF, 16'h0F0F, 8, 64'h3C);
    mdl_build(nb, sync_word, 8);
    fh = -1;
    for (int i = 0; i < nb; i++) if (exp_hv[i] && fh < 0) fh = i;
    chk("pin_post_rst_first_hv", fh, 87);
    drive(2, nb);
    mon_on = 0;
    chk("post_rst_hv_count", obs_hv, 3);

    // Randomised frames, syncs, corruptions and bit_en.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      sync_word  = 16'($urandom);
      blk        = $urandom_range(24);
      block_size = 16'(blk);
      nb = 0;
      pre = $urandom_range(30);
      if (pre > 0) push({32'd0, $urandom}, pre);
      for (int f = 0; f < 25; f++) begin
        s = ($urandom_range(4) == 0) ? (sync_word ^ (16'($urandom) | 16'd1)) : sync_word;
        push_frame(s, 16'($urandom), 16'($urandom), blk, {$urandom, $urandom});
      end
      mdl_build(nb, sync_word, blk);
      tot_hv = 0; tot_pv = 0;
      for (int i = 0; i < nb; i++) begin
        tot_hv += int'(exp_hv[i]);
        tot_pv += int'(exp_pv[i]);
      end
      drive(2, nb);
      mon_on = 0;
      chk("rand_hv_count", obs_hv, tot_hv);
      chk("rand_pv_count", obs_pv, tot_pv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dqm_deframer.md
DQM_DEFRAMER -- requirements
Module: dqm_deframer

Interface
REQ-001 SHALL have parameter HEADER_SIZE, default 48, header bits per frame: sync word plus two 16-bit header words.
REQ-002 SHALL have parameter MISS_LIMIT, default 3, consecutive sync misses tolerated before lock loss.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 bit_in  input  1  serial DQM frame stream, MSB first.
REQ-006 bit_en  input  1  qualifies bit_in; only cycles with bit_en=1 advance any state.
REQ-007 sync_word  input  16  expected frame_word_0.
REQ-008 block_size  input  16  payload bits per frame.
REQ-009 frame_word_1, frame_word_2  output  16 each  header words of the last frame.
REQ-010 header_valid  output  1  one-cycle pulse when both header words are updated.
REQ-011 payload_bit, payload_valid  output  1 each  extracted payload bit and its strobe.
REQ-012 locked  output  1  frame lock indicator.
REQ-013 interrupt  output  1  one-cycle pulse, equal to header_valid AND locked.

Function
REQ-014 SHALL implement states SEARCH, HEADER, PAYLOAD, CHECK; a 16-bit shift register shall take bit_in on every bit_en cycle in all states.
REQ-015 SEARCH: shall compare the shift register, including the current bit, to sync_word on each bit_en cycle, and on a match shall go to HEADER with bit count 0.
REQ-016 HEADER: shall collect HEADER_SIZE-16 bits, the first 16 into frame_word_1 and the next 16 into frame_word_2, through shadow registers.
REQ-017 header outputs SHALL update together, with header_valid pulsing, in the cycle after the last header bit is accepted.
REQ-018 block_size SHALL be sampled on HEADER exit and held constant for that frame's PAYLOAD.
REQ-019 HEADER exit SHALL go to PAYLOAD if the sampled block_size > 0, else directly to CHECK.
REQ-020 PAYLOAD: payload_bit shall equal bit_in, registered, with payload_valid=1 one cycle after each accepted payload bit; exactly block_size strobes per frame, then CHECK.
REQ-021 CHECK: shall collect 16 bits and compare them to sync_word.
REQ-022 CHECK match SHALL clear the miss counter, set locked, and go to HEADER.
REQ-023 CHECK mismatch SHALL increment the miss counter, which saturates at MISS_LIMIT; further action per REQ-032/033.
REQ-024 locked SHALL deassert in the same cycle that the FSM enters SEARCH.
REQ-025 payload_valid and header_valid SHALL never be asserted in the same cycle.
REQ-026 bit_en=0 SHALL freeze all counters and the FSM; pulse outputs shall still drop after one cycle.
REQ-027 sync_word changes SHALL take effect on the next comparison; no resynchronisation is forced.

Reset
REQ-028 On rst=0, state SHALL be SEARCH and all counters and the shift register shall be 0.
REQ-029 On rst=0, every output SHALL be 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; no pulses shall occur until a fresh sync match.

Configuration
REQ-031 Macro DQM_DEFRAMER_FLYWHEEL_EN SHALL select miss tolerance.
REQ-032 With DQM_DEFRAMER_FLYWHEEL_EN defined: on a CHECK mismatch with misses < MISS_LIMIT, the FSM shall stay locked and go to HEADER; on reaching MISS_LIMIT it shall go to SEARCH.
REQ-033 Without DQM_DEFRAMER_FLYWHEEL_EN: any CHECK mismatch SHALL go to SEARCH immediately; MISS_LIMIT is unused.

Structure
REQ-034 A shared package dqm_pkg SHALL hold the state enum, the DQM_SYNC_WIDTH=16 and DQM_HEADER_SIZE=48 constants, and the header word type.
REQ-035 One sub-module, dqm_sync_detect, SHALL hold the 16-bit shift register and the match comparator.
REQ-036 The FSM, counters, and header capture SHALL remain in dqm_deframer.

Verification
REQ-037 sync_word=16'hFAF3, block_size=8, frames with header FAF3/1234/5678 and payload 8'hA5 -> first header_valid gives 1234/5678; 8 payload strobes giving 1,0,1,0,0,1,0,1; locked rises at the second sync.
REQ-038 block_size=0, back-to-back 48-bit headers -> header_valid every 48 bit_en cycles; payload_valid never asserted.
REQ-039 Flywheel defined, locked, one frame with sync corrupted to 16'h0000 -> locked stays 1, header_valid continues; three consecutive corrupt syncs -> SEARCH, locked=0.
REQ-040 Flywheel undefined, locked, one corrupt sync -> locked=0 after CHECK; relock needs two good syncs.
REQ-041 bit_en toggling 1,0,0,1 throughout a frame -> identical decoded words and strobe count to the continuous case.
REQ-042 rst asserted mid-PAYLOAD -> all outputs 0 at once; after release, no header_valid until a sync match.
